// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencing controller: button FSM, stretched start/stop request, lap buffer, display select.
// Optional macro STOPWATCH_CTRL_LAP_OVERWRITE_EN: a capture into a full lap buffer overwrites the oldest entry.
module stopwatch_ctrl #(
    parameter int LAP_DEPTH = 4,
    parameter int LAP_AW    = 2
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              BTN_MODE,
    input  logic              BTN_SS,
    input  logic              BTN_LAP,
    input  logic              SLOW_TICK,
    input  logic [15:0]       SW_DIGITS,
    output logic              SW_ENABLE,
    output logic              SW_START_STOP,
    output logic              SW_CLEAR,
    output logic              SS_BUSY,
    output logic [15:0]       DISP_DIGITS,
    output logic              DISP_LAP,
    output logic [LAP_AW-1:0] LAP_IDX,
    output logic [LAP_AW:0]   LAP_COUNT,
    output logic              LAP_FULL
);

    typedef enum logic [2:0] {IDLE, READY, RUNNING, PAUSED, LAP_VIEW} state_t;

    localparam logic [LAP_AW:0]   DEPTH = (LAP_AW+1)'(LAP_DEPTH);
    localparam logic [LAP_AW-1:0] LAST  = LAP_AW'(LAP_DEPTH - 1);

    state_t            state, state_next;
    logic              ss_busy;
    logic              sw_clear;
    logic [15:0]       live_q;
    logic [15:0]       lap_mem [LAP_DEPTH];
    logic [LAP_AW-1:0] wr_ptr;
    logic [LAP_AW-1:0] rd_base;
    logic [LAP_AW-1:0] lap_idx, idx_next;
    logic [LAP_AW:0]   lap_count;
    logic [LAP_AW:0]   rd_sum;
    logic [LAP_AW-1:0] rd_addr;
    logic              issue, cancel, capture, clr_laps, pulse_clr;
    logic              full;

    function automatic logic [LAP_AW-1:0] wrap_inc(input logic [LAP_AW-1:0] p);
        return (p == LAST) ? '0 : p + 1'b1;
    endfunction

    assign full = (lap_count == DEPTH);

    // Priority MODE > SS > LAP is resolved per state among the buttons that state honours.
    always_comb begin
        state_next = state;
        idx_next   = lap_idx;
        issue      = 1'b0;
        cancel     = 1'b0;
        capture    = 1'b0;
        clr_laps   = 1'b0;
        pulse_clr  = 1'b0;
        case (state)
            IDLE: begin
                if (BTN_MODE) state_next = READY;
            end
            READY: begin
                if (BTN_MODE) begin
                    state_next = IDLE;
                    clr_laps   = 1'b1;
                end else if (BTN_SS) begin
                    if (!ss_busy) begin
                        state_next = RUNNING;
                        issue      = 1'b1;
                    end
                end else if (BTN_LAP && lap_count != '0) begin
                    state_next = LAP_VIEW;
                    idx_next   = '0;
                end
            end
            RUNNING: begin
                if (BTN_SS) begin
                    if (!ss_busy) begin
                        state_next = PAUSED;
                        issue      = 1'b1;
                    end
                end else if (BTN_LAP) begin
                    capture = 1'b1;
                end
            end
            PAUSED: begin
                if (BTN_MODE) begin
                    state_next = IDLE;
                    clr_laps   = 1'b1;
                    cancel     = 1'b1;
                end else if (BTN_SS) begin
                    if (!ss_busy) begin
                        state_next = RUNNING;
                        issue      = 1'b1;
                    end
                end else if (BTN_LAP && !ss_busy) begin
                    state_next = READY;
                    pulse_clr  = 1'b1;
                end
            end
            LAP_VIEW: begin
                if (BTN_MODE || BTN_SS) begin
                    state_next = READY;
                end else if (BTN_LAP) begin
                    idx_next = ({1'b0, lap_idx} == lap_count - 1'b1) ? '0 : lap_idx + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
        if (clr_laps) idx_next = '0;
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state     <= IDLE;
            ss_busy   <= 1'b0;
            sw_clear  <= 1'b0;
            live_q    <= '0;
            lap_idx   <= '0;
            lap_count <= '0;
            wr_ptr    <= '0;
            rd_base   <= '0;
            for (int unsigned i = 0; i < LAP_DEPTH; i++) lap_mem[i] <= '0;
        end else begin
            state    <= state_next;
            sw_clear <= pulse_clr;
            live_q   <= SW_DIGITS;
            lap_idx  <= idx_next;
            // Request set at acceptance, so a tick in that same cycle is not counted.
            if (issue)
                ss_busy <= 1'b1;
            else if (cancel || SLOW_TICK)
                ss_busy <= 1'b0;
            if (clr_laps) begin
                lap_count <= '0;
                wr_ptr    <= '0;
                rd_base   <= '0;
            end else if (capture) begin
                if (!full) begin
                    lap_mem[wr_ptr] <= SW_DIGITS;
                    wr_ptr          <= wrap_inc(wr_ptr);
                    lap_count       <= lap_count + 1'b1;
                end
`ifdef STOPWATCH_CTRL_LAP_OVERWRITE_EN
                else begin
                    lap_mem[wr_ptr] <= SW_DIGITS;
                    wr_ptr          <= wrap_inc(wr_ptr);
                    rd_base         <= wrap_inc(rd_base);
                end
`endif
            end
        end
    end

    always_comb begin
        rd_sum = {1'b0, rd_base} + {1'b0, lap_idx};
        if (rd_sum >= DEPTH) rd_sum = rd_sum - DEPTH;
        rd_addr = rd_sum[LAP_AW-1:0];
    end

    always_comb begin
        DISP_DIGITS = live_q;
        if (state == LAP_VIEW)
            DISP_DIGITS = lap_mem[rd_addr];
        else if (state == IDLE)
            DISP_DIGITS = '0;
    end

    assign SW_ENABLE     = (state != IDLE);
    assign SW_START_STOP = ss_busy;
    assign SS_BUSY       = ss_busy;
    assign SW_CLEAR      = sw_clear;
    assign DISP_LAP      = (state == LAP_VIEW);
    assign LAP_IDX       = lap_idx;
    assign LAP_COUNT     = lap_count;
    assign LAP_FULL      = full;

endmodule
